// File: rtl/contador_updown_mod.sv
// ----------------------------------------------------------------------------
// contador_updown_mod
//   Parametrised synchronous up/down modulo counter. It has a parallel load,
//   a count enable and a combinational terminal-count flag that can be used
//   to cascade counters. It is meant as the common counting primitive for
//   dividers, timers and sequencers.
//
// Parameters
//   WIDTH    counter width in bits
//   MODULO   count range 0..MODULO-1 (2 <= MODULO <= 2**WIDTH)
//   RST_VAL  value forced by clear (0 <= RST_VAL < MODULO)
//
// Ports
//   clk   in   1      clock, rising edge
//   clr   in   1      asynchronous clear, active-low (q = RST_VAL)
//   en    in   1      count enable
//   up    in   1      direction: 1 = up, 0 = down
//   load  in   1      synchronous load of d (clamped to MODULO-1); beats en
//   d     in   WIDTH  load value
//   q     out  WIDTH  registered count
//   tc    out  1      next enabled step wraps (or saturates)
//
// Build option
//   CONTADOR_SAT_EN : when defined, the counter saturates at the ends of the
//                     range instead of wrapping. The tc behaviour is unchanged.
// ----------------------------------------------------------------------------
module contador_updown_mod #(
    parameter int WIDTH   = 6,
    parameter int MODULO  = 64,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RST_VAL);
    // The modulus is kept one bit wider so that the clamp compare still works
    // when MODULO == 2**WIDTH, where it does not fit in WIDTH bits.
    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULO);

    logic             at_max;
    logic             at_min;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] up_val;
    logic [WIDTH-1:0] dn_val;
    logic [WIDTH-1:0] q_nxt;

    assign at_max   = (q == MAX_Q);
    assign at_min   = (q == '0);
    assign load_val = ({1'b0, d} < MOD_W) ? d : MAX_Q;

`ifdef CONTADOR_SAT_EN
    assign up_val = at_max ? MAX_Q : q + WIDTH'(1);
    assign dn_val = at_min ? '0    : q - WIDTH'(1);
`else
    // The explicit wrap compare is needed for non-power-of-two moduli. When
    // MODULO == 2**WIDTH it gives the same result as natural overflow.
    assign up_val = at_max ? '0    : q + WIDTH'(1);
    assign dn_val = at_min ? MAX_Q : q - WIDTH'(1);
`endif

    always_comb begin
        q_nxt = q;
        if (load)
            q_nxt = load_val;
        else if (en)
            q_nxt = up ? up_val : dn_val;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr)
            q <= RST_Q;
        else
            q <= q_nxt;
    end

    // The clr term forces tc low while the counter is held in clear.
    assign tc = clr & en & ~load & ((up & at_max) | (~up & at_min));

endmodule

// File: tb/tb_contador_updown_mod.sv
// ----------------------------------------------------------------------------
// tb_contador_updown_mod
//   Self-checking bench for contador_updown_mod. It drives two instances from
//   the same stimulus:
//     u_a : defaults (WIDTH=6, MODULO=64, RST_VAL=0), so the modulus fills the
//           full binary range
//     u_b : WIDTH=4, MODULO=10, RST_VAL=0, so the modulus is not a power of two
//   The bench first applies directed sequences, then random traffic. Both
//   counters are compared every cycle against an integer model of the rules.
//   The same model covers the wrap build and the CONTADOR_SAT_EN build.
// ----------------------------------------------------------------------------
module tb_contador_updown_mod;

`ifdef CONTADOR_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk  = 1'b0;
    logic       clr  = 1'b0;
    logic       en   = 1'b0;
    logic       up   = 1'b0;
    logic       load = 1'b0;
    logic [5:0] d    = '0;
    logic [5:0] qa;
    logic [3:0] qb;
    logic       tca;
    logic       tcb;

    int mqa = 0;
    int mqb = 0;
    int n_vec = 0;
    int n_err = 0;

    always #10 clk = ~clk;

    contador_updown_mod u_a (
        .clk(clk), .clr(clr), .en(en), .up(up), .load(load),
        .d(d), .q(qa), .tc(tca)
    );

    contador_updown_mod #(.WIDTH(4), .MODULO(10), .RST_VAL(0)) u_b (
        .clk(clk), .clr(clr), .en(en), .up(up), .load(load),
        .d(d[3:0]), .q(qb), .tc(tcb)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Next value of a modulo-m counter, taken directly from the rules.
    function automatic int nxt(input int q, input int m, input bit e,
                               input bit u, input bit l, input int dv);
        if (l)  return (dv < m) ? dv : m - 1;
        if (!e) return q;
        if (u)  return (q == m - 1) ? (SAT ? q : 0) : q + 1;
        return (q == 0) ? (SAT ? 0 : m - 1) : q - 1;
    endfunction

    function automatic bit tcf(input int q, input int m, input bit c,
                               input bit e, input bit u, input bit l);
        return c && e && !l && ((u && q == m - 1) || (!u && q == 0));
    endfunction

    // Each step does four things: it applies the inputs, checks q and tc on
    // the following falling edge, lets a rising edge pass, and then advances
    // the model with the inputs that edge sampled.
    task automatic step(input bit c, input bit e, input bit u, input bit l,
                        input int dv);
        clr = c; en = e; up = u; load = l; d = dv[5:0];
        if (!c) begin mqa = 0; mqb = 0; end
        @(negedge clk);
        chk("qa",  int'(qa),  mqa);
        chk("tca", int'(tca), int'(tcf(mqa, 64, c, e, u, l)));
        chk("qb",  int'(qb),  mqb);
        chk("tcb", int'(tcb), int'(tcf(mqb, 10, c, e, u, l)));
        @(posedge clk);
        if (c) begin
            mqa = nxt(mqa, 64, e, u, l, dv & 63);
            mqb = nxt(mqb, 10, e, u, l, dv & 15);
        end
        #1;
    endtask

    initial begin
        // Reset state while clr is low from time zero.
        #5;
        chk("rst_qa", int'(qa), 0);
        chk("rst_qb", int'(qb), 0);
        chk("rst_tca", int'(tca), 0);
        @(posedge clk); #1;
        step(0, 1, 1, 1, 9);                     // clr low: load/en ignored

        // Count to 37, then clear asynchronously in the middle of a cycle.
        step(1, 0, 1, 1, 37);
        step(1, 1, 1, 0, 0);                     // A: 37 -> 38
        clr = 1'b0;
        #3;
        chk("aclr_qa", int'(qa), 0);
        chk("aclr_qb", int'(qb), 0);
        chk("aclr_tca", int'(tca), 0);
        mqa = 0; mqb = 0;
        step(0, 1, 1, 1, 9);
        step(0, 1, 0, 0, 0);

        // Down wrap starting from 0.
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0);

        // Up across the mod-10 boundary (B) from 0.
        step(1, 0, 1, 1, 0);
        for (int i = 0; i < 12; i++) step(1, 1, 1, 0, 0);

        // Load beats enable; an out-of-range value is clamped in B.
        step(1, 1, 1, 1, 5);
        step(1, 1, 1, 1, 12);
        step(1, 1, 1, 0, 0);

        // Hold with en=0, then reverse direction around 20 (A).
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0);
        step(1, 0, 1, 1, 20);
        step(1, 1, 1, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);

        // Ends of the range for A: from 62 upward, then from 1 downward.
        step(1, 0, 1, 1, 62);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 0);
        step(1, 0, 1, 1, 1);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 500; i++)
            step($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0,
                 int'($urandom_range(0, 63)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
